square_state_controller: RTL and testbench
==========================================

Name: square_state_controller

Overview:
- Owns the per-square state array for the brick field: strong, okay, weak, invincible or empty.
- Accepts collision hits from the ball logic and downgrades the hit square one step per hit.
- Loads level patterns by sweeping the array once.
- Serves a read port to the VGA square renderer, which maps the returned state to a colour.
- Generates the cycling RANDOM_RGB colour used for invincible squares.

Parameters:
- NUM_SQUARES, 16, number of squares in the field (2..256).
- INDEX_WIDTH, 4, width of the square index; must satisfy 2**INDEX_WIDTH >= NUM_SQUARES.
- COLOR_DIV, 2500000, clock cycles between RANDOM_RGB updates (>=1).
- LFSR_SEED, 12'hACE, non-zero reset seed for the colour LFSR.
- RESET_MASK, 16'h0000, invincible-square mask applied by the reset-time load sweep.

Ports:
- CLK  input  1  system clock.
- RST  input  1  reset.
- LOAD  input  1  one-cycle pulse; start a level-load sweep using LOAD_MASK.
- LOAD_MASK  input  NUM_SQUARES  bit i=1 makes square i invincible, else strong; sampled on the LOAD cycle.
- HIT_VALID  input  1  hit request.
- HIT_INDEX  input  INDEX_WIDTH  square hit.
- HIT_READY  output  1  controller can accept a hit this cycle.
- RD_INDEX  input  INDEX_WIDTH  renderer read address.
- RD_STATE  output  SQUARE_STATE_ENCODE_LENGTH  state of square RD_INDEX (combinational).
- RANDOM_RGB  output  12  invincible-square colour.
- SCORE_PULSE  output  1  one-cycle pulse when a square becomes empty.
- REMAINING  output  INDEX_WIDTH+1  count of breakable (non-empty, non-invincible) squares.
- ALL_CLEARED  output  1  high when REMAINING==0 and state is IDLE.
- BUSY  output  1  high during the load sweep.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous and active-high.
- Reset values:
  - FSM=LOAD_SWEEP, sweep index 0, latched mask=RESET_MASK.
  - LFSR=LFSR_SEED, divider=0.
  - SCORE_PULSE=0, REMAINING=0, BUSY=1, HIT_READY=0.
  - RESET_MASK/sweep results are all visible NUM_SQUARES cycles after RST falls.
- FSM has two states: LOAD_SWEEP and IDLE.
- LOAD_SWEEP:
  - Each cycle writes square[idx] = INVINCIBLE if mask[idx], else STRONG.
  - REMAINING counts up for each STRONG written; idx increments.
  - After writing idx=NUM_SQUARES-1, go to IDLE.
  - Sweep takes exactly NUM_SQUARES cycles. BUSY=1, HIT_READY=0 throughout.
- IDLE:
  - HIT_READY=1. A hit is accepted on a cycle with HIT_VALID && HIT_READY.
  - The new state is written on the accepting edge and visible on RD_STATE the next cycle.
  - LOAD in IDLE latches LOAD_MASK, zeroes REMAINING, resets idx=0 and enters LOAD_SWEEP next cycle.
- Downgrade rule on an accepted hit:
  - STRONG->OKAY, OKAY->WEAK.
  - WEAK->EMPTY: REMAINING decrements and SCORE_PULSE=1 in the following cycle.
  - INVINCIBLE and EMPTY: unchanged, no pulse.
- Boundaries:
  - HIT_INDEX >= NUM_SQUARES: accepted, no state change, no pulse.
  - LOAD and HIT_VALID in the same IDLE cycle: LOAD wins and the hit is not accepted. HIT_READY drops combinationally when LOAD=1.
  - LOAD during LOAD_SWEEP: restarts the sweep at idx 0 with the new mask.
  - RST mid-sweep or mid-hit: full reset, no partial write.
- RD_STATE:
  - Pure combinational read of square[RD_INDEX], including during a sweep (partially loaded contents are visible).
  - RD_INDEX >= NUM_SQUARES returns SQUARE_EMPTY.
- RANDOM_RGB:
  - 12-bit Fibonacci LFSR, taps 12,11,10,4, shifts once when the divider reaches COLOR_DIV-1, then the divider wraps to 0.
  - Never reaches zero; runs in all FSM states.
- ALL_CLEARED: registered compare, updated one cycle after REMAINING changes; forced 0 in LOAD_SWEEP.

Decomposition:
- Head.v gains:
  - SQUARE_EMPTY encoding; SQUARE_STATE_ENCODE_LENGTH becomes 3 so that five states fit.
  - FSM state defines (CTRL_IDLE, CTRL_LOAD_SWEEP).
  - The LFSR tap constant.
- Existing SQUARE_STRONG, SQUARE_OKAY, SQUARE_WEAK and SQUARE_INVINCIBLE codes are unchanged.
- One natural sub-module: random_rgb_lfsr (divider plus LFSR, with parameters COLOR_DIV and LFSR_SEED), reusable elsewhere in the game.

Test Plan:
- Reset and sweep: RST high 2 cycles, RESET_MASK=16'h0003, NUM_SQUARES=16 -> BUSY high 16 cycles; then squares 0,1 read INVINCIBLE, 2..15 read STRONG, REMAINING=14, HIT_READY=1.
- Downgrade chain: three hits to index 5 -> STRONG, OKAY, WEAK, EMPTY on successive reads; SCORE_PULSE exactly once, the cycle after the third hit; REMAINING 14->13.
- Invincible and out-of-range: hit index 0 and hit index 15 with NUM_SQUARES=12 -> no state change, no SCORE_PULSE; RD_INDEX=13 returns SQUARE_EMPTY.
- Clear all: LOAD with mask 16'hFFFE, then 3 hits on square 0 -> REMAINING=0, ALL_CLEARED=1 one cycle later.
- LOAD/HIT collision: LOAD and HIT_VALID (index 4) in the same cycle -> hit not accepted (HIT_READY=0), sweep restarts, square 4 STRONG afterwards.
- LFSR: COLOR_DIV=3, seed 12'hACE -> RANDOM_RGB changes every 3rd cycle, matches the reference model for 4095 steps, never 0, period 4095.

Source files
------------

// File: rtl/square_state_controller_pkg.sv
// Shared encodings for the brick-field square controller: square states,
// controller FSM states and the colour LFSR tap mask.
package square_state_controller_pkg;

    localparam int unsigned SQUARE_STATE_ENCODE_LENGTH = 3;
    localparam int unsigned LFSR_WIDTH                 = 12;

    // Taps 12,11,10,4 expressed as a bit mask over lfsr[11:0].
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 12'hE08;

    typedef enum logic [SQUARE_STATE_ENCODE_LENGTH-1:0] {
        SQUARE_STRONG     = 3'd0,
        SQUARE_OKAY       = 3'd1,
        SQUARE_WEAK       = 3'd2,
        SQUARE_INVINCIBLE = 3'd3,
        SQUARE_EMPTY      = 3'd4
    } square_state_t;

    typedef enum logic {
        CTRL_IDLE       = 1'b0,
        CTRL_LOAD_SWEEP = 1'b1
    } ctrl_state_t;

    // One downgrade step per accepted hit; invincible and empty squares are sticky.
    function automatic square_state_t downgrade(input square_state_t s);
        case (s)
            SQUARE_STRONG: downgrade = SQUARE_OKAY;
            SQUARE_OKAY:   downgrade = SQUARE_WEAK;
            SQUARE_WEAK:   downgrade = SQUARE_EMPTY;
            default:       downgrade = s;
        endcase
    endfunction

endpackage

// File: rtl/square_state_controller_random_rgb_lfsr.sv
// Divided-clock 12-bit Fibonacci LFSR producing the cycling colour for
// invincible squares; free-running in every controller state.
module random_rgb_lfsr
    import square_state_controller_pkg::*;
#(
    parameter int unsigned            COLOR_DIV = 2500000,
    parameter logic [LFSR_WIDTH-1:0]  LFSR_SEED = 12'hACE
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [LFSR_WIDTH-1:0] rgb
);

    localparam int unsigned DIV_W = (COLOR_DIV > 1) ? $clog2(COLOR_DIV) : 1;

    logic [DIV_W-1:0]      div_q;
    logic [LFSR_WIDTH-1:0] lfsr_q;
    logic                  tick_c;

    assign tick_c = (32'(div_q) == (COLOR_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            lfsr_q <= LFSR_SEED;
        end else if (tick_c) begin
            div_q  <= '0;
            lfsr_q <= {lfsr_q[LFSR_WIDTH-2:0], ^(lfsr_q & LFSR_TAPS)};
        end else begin
            div_q  <= div_q + DIV_W'(1);
        end
    end

    assign rgb = lfsr_q;

endmodule

// File: rtl/square_state_controller.sv
// Per-square state array for the brick field: level-load sweep, hit
// downgrades, renderer read port, remaining-count and cleared flag.
module square_state_controller
    import square_state_controller_pkg::*;
#(
    parameter int unsigned              NUM_SQUARES = 16,
    parameter int unsigned              INDEX_WIDTH = 4,
    parameter int unsigned              COLOR_DIV   = 2500000,
    parameter logic [LFSR_WIDTH-1:0]    LFSR_SEED   = 12'hACE,
    parameter logic [NUM_SQUARES-1:0]   RESET_MASK  = '0
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic                                  LOAD,
    input  logic [NUM_SQUARES-1:0]                LOAD_MASK,
    input  logic                                  HIT_VALID,
    input  logic [INDEX_WIDTH-1:0]                HIT_INDEX,
    output logic                                  HIT_READY,
    input  logic [INDEX_WIDTH-1:0]                RD_INDEX,
    output logic [SQUARE_STATE_ENCODE_LENGTH-1:0] RD_STATE,
    output logic [LFSR_WIDTH-1:0]                 RANDOM_RGB,
    output logic                                  SCORE_PULSE,
    output logic [INDEX_WIDTH:0]                  REMAINING,
    output logic                                  ALL_CLEARED,
    output logic                                  BUSY
);

    localparam int unsigned CNT_W = INDEX_WIDTH + 1;

    ctrl_state_t              state_q;
    logic [INDEX_WIDTH-1:0]   idx_q;
    logic [NUM_SQUARES-1:0]   mask_q;
    square_state_t            squares_q [NUM_SQUARES];
    logic [CNT_W-1:0]         remaining_q;
    logic                     score_pulse_q;
    logic                     all_cleared_q;

    logic                     hit_in_range_c;
    logic                     last_idx_c;

    assign hit_in_range_c = (32'(HIT_INDEX) < NUM_SQUARES);
    assign last_idx_c     = (32'(idx_q) == (NUM_SQUARES - 1));

    // LOAD takes priority over a same-cycle hit, so readiness drops with it.
    assign HIT_READY = (state_q == CTRL_IDLE) && !LOAD;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= CTRL_LOAD_SWEEP;
            idx_q         <= '0;
            mask_q        <= RESET_MASK;
            remaining_q   <= '0;
            score_pulse_q <= 1'b0;
            all_cleared_q <= 1'b0;
            for (int i = 0; i < int'(NUM_SQUARES); i++) begin
                squares_q[i] <= SQUARE_EMPTY;
            end
        end else begin
            score_pulse_q <= 1'b0;
            all_cleared_q <= 1'b0;
            if (LOAD) begin
                state_q     <= CTRL_LOAD_SWEEP;
                mask_q      <= LOAD_MASK;
                idx_q       <= '0;
                remaining_q <= '0;
            end else begin
                case (state_q)
                    CTRL_LOAD_SWEEP: begin
                        squares_q[idx_q] <= mask_q[idx_q] ? SQUARE_INVINCIBLE : SQUARE_STRONG;
                        if (!mask_q[idx_q]) begin
                            remaining_q <= remaining_q + CNT_W'(1);
                        end
                        if (last_idx_c) begin
                            state_q <= CTRL_IDLE;
                            idx_q   <= '0;
                        end else begin
                            idx_q   <= idx_q + INDEX_WIDTH'(1);
                        end
                    end
                    CTRL_IDLE: begin
                        all_cleared_q <= (remaining_q == '0);
                        // Out-of-range hits are accepted but leave the field untouched.
                        if (HIT_VALID && hit_in_range_c) begin
                            squares_q[HIT_INDEX] <= downgrade(squares_q[HIT_INDEX]);
                            if (squares_q[HIT_INDEX] == SQUARE_WEAK) begin
                                remaining_q   <= remaining_q - CNT_W'(1);
                                score_pulse_q <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= CTRL_IDLE;
                endcase
            end
        end
    end

    assign RD_STATE    = (32'(RD_INDEX) < NUM_SQUARES) ? squares_q[RD_INDEX] : SQUARE_EMPTY;
    assign SCORE_PULSE = score_pulse_q;
    assign REMAINING   = remaining_q;
    assign ALL_CLEARED = all_cleared_q;
    assign BUSY        = (state_q == CTRL_LOAD_SWEEP);

    random_rgb_lfsr #(
        .COLOR_DIV (COLOR_DIV),
        .LFSR_SEED (LFSR_SEED)
    ) u_random_rgb_lfsr (
        .clk (CLK),
        .rst (RST),
        .rgb (RANDOM_RGB)
    );

endmodule

// File: tb/tb_square_state_controller.sv
// Scoreboard bench for square_state_controller: stimulus queues expected
// values, a negedge monitor pops and compares them.
module tb_square_state_controller;

    localparam logic [2:0] ST_STRONG = 3'd0;
    localparam logic [2:0] ST_OKAY   = 3'd1;
    localparam logic [2:0] ST_WEAK   = 3'd2;
    localparam logic [2:0] ST_INV    = 3'd3;
    localparam logic [2:0] ST_EMPTY  = 3'd4;

    localparam int S_RD = 0, S_REM = 1, S_RDY = 2, S_BUSY = 3, S_CLR = 4, S_PULSE = 5;
    localparam int S_RD12 = 6, S_REM12 = 7, S_PULSE12 = 8, S_RDY12 = 9;
    localparam int S_PQ = 10, S_LFDONE = 11, S_LFZERO = 12, S_LFEARLY = 13;

    logic        CLK, RST;
    logic        LOAD, HIT_VALID, HIT_READY, SCORE_PULSE, ALL_CLEARED, BUSY;
    logic [15:0] LOAD_MASK;
    logic [3:0]  HIT_INDEX, RD_INDEX;
    logic [2:0]  RD_STATE;
    logic [11:0] RANDOM_RGB;
    logic [4:0]  REMAINING;

    logic        LOAD_12, HIT_VALID_12, HIT_READY_12, SCORE_PULSE_12, ALL_CLEARED_12, BUSY_12;
    logic [11:0] LOAD_MASK_12;
    logic [3:0]  HIT_INDEX_12, RD_INDEX_12;
    logic [2:0]  RD_STATE_12;
    logic [11:0] RANDOM_RGB_12;
    logic [4:0]  REMAINING_12;

    square_state_controller #(
        .NUM_SQUARES(16), .INDEX_WIDTH(4), .COLOR_DIV(3),
        .LFSR_SEED(12'hACE), .RESET_MASK(16'h0003)
    ) dut (
        .CLK(CLK), .RST(RST), .LOAD(LOAD), .LOAD_MASK(LOAD_MASK),
        .HIT_VALID(HIT_VALID), .HIT_INDEX(HIT_INDEX), .HIT_READY(HIT_READY),
        .RD_INDEX(RD_INDEX), .RD_STATE(RD_STATE), .RANDOM_RGB(RANDOM_RGB),
        .SCORE_PULSE(SCORE_PULSE), .REMAINING(REMAINING),
        .ALL_CLEARED(ALL_CLEARED), .BUSY(BUSY)
    );

    square_state_controller #(
        .NUM_SQUARES(12), .INDEX_WIDTH(4), .COLOR_DIV(3),
        .LFSR_SEED(12'hACE), .RESET_MASK(12'h001)
    ) dut12 (
        .CLK(CLK), .RST(RST), .LOAD(LOAD_12), .LOAD_MASK(LOAD_MASK_12),
        .HIT_VALID(HIT_VALID_12), .HIT_INDEX(HIT_INDEX_12), .HIT_READY(HIT_READY_12),
        .RD_INDEX(RD_INDEX_12), .RD_STATE(RD_STATE_12), .RANDOM_RGB(RANDOM_RGB_12),
        .SCORE_PULSE(SCORE_PULSE_12), .REMAINING(REMAINING_12),
        .ALL_CLEARED(ALL_CLEARED_12), .BUSY(BUSY_12)
    );

    typedef struct {
        string       name;
        int          sel;
        logic [15:0] exp;
    } check_t;

    check_t check_q[$];
    int     pulse_q[$];
    check_t mon_c;
    int     total = 0;
    int     bad   = 0;
    int     cyc   = 0;
    int     mon_bad0;

    logic [11:0] lf_model = 12'hACE;
    logic [11:0] lf_prev  = 12'hACE;
    int          lf_steps = 0;
    int          lf_last  = 0;
    int          lf_fail  = 0;
    bit          lf_armed = 1'b0;
    bit          lf_done  = 1'b0;
    bit          lf_zero  = 1'b0;
    bit          lf_early = 1'b0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [15:0] probe(input int sel);
        case (sel)
            S_RD:      probe = 16'(RD_STATE);
            S_REM:     probe = 16'(REMAINING);
            S_RDY:     probe = 16'(HIT_READY);
            S_BUSY:    probe = 16'(BUSY);
            S_CLR:     probe = 16'(ALL_CLEARED);
            S_PULSE:   probe = 16'(SCORE_PULSE);
            S_RD12:    probe = 16'(RD_STATE_12);
            S_REM12:   probe = 16'(REMAINING_12);
            S_PULSE12: probe = 16'(SCORE_PULSE_12);
            S_RDY12:   probe = 16'(HIT_READY_12);
            S_PQ:      probe = 16'(pulse_q.size());
            S_LFDONE:  probe = 16'(lf_done);
            S_LFZERO:  probe = 16'(lf_zero);
            S_LFEARLY: probe = 16'(lf_early);
            default:   probe = 16'hDEAD;
        endcase
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: drains queued expectations, tracks score pulses and the colour LFSR.
    always @(negedge CLK) begin
        while (check_q.size() > 0) begin
            mon_c = check_q.pop_front();
            check(mon_c.name, probe(mon_c.sel), mon_c.exp);
        end
        if (SCORE_PULSE === 1'b1) begin
            if (pulse_q.size() > 0) check("score_pulse_cycle", 16'(cyc), 16'(pulse_q.pop_front()));
            else                    check("score_pulse_unexpected", 16'(SCORE_PULSE), 16'd0);
        end
        if (lf_armed && !lf_done && RANDOM_RGB !== lf_prev) begin
            lf_model = {lf_model[10:0], lf_model[11] ^ lf_model[10] ^ lf_model[9] ^ lf_model[3]};
            lf_steps++;
            mon_bad0 = bad;
            check("rgb_value", 16'(RANDOM_RGB), 16'(lf_model));
            if (lf_steps > 1) check("rgb_interval", 16'(cyc - lf_last), 16'd3);
            if (bad != mon_bad0) lf_fail++;
            lf_model = RANDOM_RGB;
            lf_last  = cyc;
            if (RANDOM_RGB == 12'h000) lf_zero = 1'b1;
            if (RANDOM_RGB == 12'hACE && lf_steps < 4095) lf_early = 1'b1;
            if (lf_steps == 4095) begin
                check("rgb_period", 16'(RANDOM_RGB), 16'h0ACE);
                lf_done = 1'b1;
            end
            if (lf_fail >= 8) lf_done = 1'b1;
            lf_prev = RANDOM_RGB;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_val(input string name, input int sel, input logic [15:0] exp);
        check_q.push_back('{name: name, sel: sel, exp: exp});
    endtask

    task automatic hit(input logic [3:0] idx);
        HIT_VALID = 1'b1;
        HIT_INDEX = idx;
        tick();
        HIT_VALID = 1'b0;
    endtask

    initial begin
        RST = 1'b1; LOAD = 1'b0; LOAD_MASK = '0; HIT_VALID = 1'b0; HIT_INDEX = '0; RD_INDEX = '0;
        LOAD_12 = 1'b0; LOAD_MASK_12 = '0; HIT_VALID_12 = 1'b0; HIT_INDEX_12 = '0; RD_INDEX_12 = '0;
        tick();
        tick();
        expect_val("rst_busy", S_BUSY, 16'd1);
        expect_val("rst_ready", S_RDY, 16'd0);
        expect_val("rst_remaining", S_REM, 16'd0);
        expect_val("rst_pulse", S_PULSE, 16'd0);
        RST = 1'b0;
        lf_armed = 1'b1;

        // Reset-time sweep: busy for exactly 16 cycles, then mask 0x0003 visible.
        for (int i = 0; i < 16; i++) begin
            expect_val("sweep_busy", S_BUSY, 16'd1);
            tick();
        end
        expect_val("sweep_done_busy", S_BUSY, 16'd0);
        expect_val("sweep_done_ready", S_RDY, 16'd1);
        expect_val("sweep_remaining", S_REM, 16'd14);
        for (int i = 0; i < 16; i++) begin
            RD_INDEX = 4'(i);
            expect_val("sweep_read", S_RD, (i < 2) ? 16'(ST_INV) : 16'(ST_STRONG));
            tick();
        end

        // 12-square instance: invincible and out-of-range hits, out-of-range read.
        HIT_VALID_12 = 1'b1;
        HIT_INDEX_12 = 4'd0;
        expect_val("n12_ready", S_RDY12, 16'd1);
        tick();
        HIT_INDEX_12 = 4'd15;
        expect_val("n12_pulse_inv", S_PULSE12, 16'd0);
        tick();
        HIT_VALID_12 = 1'b0;
        expect_val("n12_pulse_oor", S_PULSE12, 16'd0);
        RD_INDEX_12 = 4'd0;
        expect_val("n12_inv_kept", S_RD12, 16'(ST_INV));
        expect_val("n12_remaining", S_REM12, 16'd11);
        tick();
        RD_INDEX_12 = 4'd13;
        expect_val("n12_read_oor", S_RD12, 16'(ST_EMPTY));
        tick();
        RD_INDEX_12 = 4'd11;
        expect_val("n12_last_strong", S_RD12, 16'(ST_STRONG));
        expect_val("n12_pulse_quiet", S_PULSE12, 16'd0);
        tick();

        // Downgrade chain on square 5.
        RD_INDEX = 4'd5;
        hit(4'd5);
        expect_val("chain_okay", S_RD, 16'(ST_OKAY));
        hit(4'd5);
        expect_val("chain_weak", S_RD, 16'(ST_WEAK));
        pulse_q.push_back(cyc + 1);
        hit(4'd5);
        expect_val("chain_empty", S_RD, 16'(ST_EMPTY));
        expect_val("chain_remaining", S_REM, 16'd13);
        expect_val("chain_pulse", S_PULSE, 16'd1);
        tick();
        expect_val("chain_pulse_once", S_PULSE, 16'd0);
        hit(4'd5);
        expect_val("empty_stays", S_RD, 16'(ST_EMPTY));
        expect_val("empty_remaining", S_REM, 16'd13);
        tick();

        // Invincible square ignores hits.
        RD_INDEX = 4'd0;
        hit(4'd0);
        expect_val("inv_stays", S_RD, 16'(ST_INV));
        tick();

        // LOAD and hit in the same cycle: hit on a WEAK square must be dropped.
        hit(4'd4);
        hit(4'd4);
        RD_INDEX = 4'd4;
        expect_val("pre_collide_weak", S_RD, 16'(ST_WEAK));
        tick();
        LOAD = 1'b1; LOAD_MASK = 16'h0000; HIT_VALID = 1'b1; HIT_INDEX = 4'd4;
        expect_val("collide_ready", S_RDY, 16'd0);
        expect_val("collide_busy_pre", S_BUSY, 16'd0);
        tick();
        LOAD = 1'b0; HIT_VALID = 1'b0;
        expect_val("collide_busy", S_BUSY, 16'd1);
        expect_val("collide_no_pulse", S_PULSE, 16'd0);
        expect_val("collide_rem_zeroed", S_REM, 16'd0);
        repeat (16) tick();
        expect_val("collide_done", S_BUSY, 16'd0);
        expect_val("collide_remaining", S_REM, 16'd16);
        expect_val("collide_sq4", S_RD, 16'(ST_STRONG));
        tick();
        RD_INDEX = 4'd5;
        expect_val("collide_sq5", S_RD, 16'(ST_STRONG));
        tick();

        // Clear all: restarted sweep with mask 0xFFFE, then break square 0.
        LOAD = 1'b1; LOAD_MASK = 16'h0000;
        tick();
        LOAD = 1'b0;
        repeat (4) tick();
        expect_val("restart_busy", S_BUSY, 16'd1);
        LOAD = 1'b1; LOAD_MASK = 16'hFFFE;
        tick();
        LOAD = 1'b0;
        repeat (16) tick();
        expect_val("clear_busy", S_BUSY, 16'd0);
        expect_val("clear_remaining", S_REM, 16'd1);
        expect_val("clear_flag_low", S_CLR, 16'd0);
        RD_INDEX = 4'd1;
        expect_val("clear_sq1_inv", S_RD, 16'(ST_INV));
        tick();
        RD_INDEX = 4'd0;
        expect_val("clear_sq0_strong", S_RD, 16'(ST_STRONG));
        hit(4'd0);
        hit(4'd0);
        pulse_q.push_back(cyc + 1);
        hit(4'd0);
        expect_val("clear_rem_zero", S_REM, 16'd0);
        expect_val("clear_flag_lag", S_CLR, 16'd0);
        expect_val("clear_sq0_empty", S_RD, 16'(ST_EMPTY));
        tick();
        expect_val("clear_flag_set", S_CLR, 16'd1);
        tick();
        LOAD = 1'b1; LOAD_MASK = 16'h0000;
        tick();
        LOAD = 1'b0;
        expect_val("reload_flag_forced", S_CLR, 16'd0);
        expect_val("reload_busy", S_BUSY, 16'd1);
        repeat (16) tick();
        expect_val("reload_remaining", S_REM, 16'd16);
        tick();

        // Let the colour LFSR run a full period, bounded.
        for (int i = 0; i < 20000 && !lf_done; i++) tick();
        expect_val("rgb_steps_done", S_LFDONE, 16'd1);
        expect_val("rgb_never_zero", S_LFZERO, 16'd0);
        expect_val("rgb_no_early_repeat", S_LFEARLY, 16'd0);
        expect_val("score_pulse_missing", S_PQ, 16'd0);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
